// File: rtl/spi_slave_bus_sequencer.sv
// Bus sequencer behind the SPI slave ctrl port: single-beat writes, prefetching reads,
// address auto-increment with optional wrap, cs-driven drain back to idle.
module spi_slave_bus_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PF_DEPTH   = 4
) (
  input  logic                    sclk,
  input  logic                    sys_rstn,
  input  logic                    cs,
  input  logic                    ctrl_rd_wr,
  input  logic [ADDR_WIDTH-1:0]   ctrl_addr,
  input  logic                    ctrl_addr_valid,
  input  logic [DATA_WIDTH-1:0]   ctrl_data_rx,
  input  logic                    ctrl_data_rx_valid,
  output logic                    ctrl_data_rx_ready,
  output logic [DATA_WIDTH-1:0]   ctrl_data_tx,
  output logic                    ctrl_data_tx_valid,
  input  logic                    ctrl_data_tx_ready,
  input  logic [15:0]             wrap_length,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    busy,
  output logic                    err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW    = $clog2(PF_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CW:0] PF_LIMIT = (CW+1)'(PF_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           offset_q, offset_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [PF_DEPTH];

  logic        rx_ready;
  logic        tx_valid;
  logic        gnt_fire;
  logic        rd_gnt;
  logic        rd_ret;
  logic        push_en;
  logic        pop_en;
  logic        flush;
  logic [15:0] offset_next;
  logic [CW:0] credit_used;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    offset_d      = offset_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_wdata_d   = bus_wdata_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    rx_ready = (state_q == WRITE) && !bus_req_q;
    tx_valid = (state_q == READ) && (count_q != '0);
    gnt_fire = bus_req_q && bus_gnt;
    rd_gnt   = gnt_fire && !bus_we_q;
    rd_ret   = bus_rvalid && (outstanding_q != '0);
    push_en  = rd_ret && (state_q == READ);
    pop_en   = tx_valid && ctrl_data_tx_ready;
    flush    = cs && (state_q == READ);

    offset_next = offset_q + 16'd1;
    if ((wrap_length != 16'd0) && (offset_next == wrap_length)) offset_next = 16'd0;
    if (gnt_fire) offset_d = offset_next;

    case ({rd_gnt, rd_ret})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{(CW-1){1'b0}}, push_en} - {{(CW-1){1'b0}}, pop_en};
    end

    credit_used = {1'b0, count_d} + {1'b0, outstanding_d};

    if (ctrl_addr_valid && (state_q != IDLE)) err_d = 1'b1;
    if (bus_rvalid && (outstanding_q == '0))  err_d = 1'b1;
    if (ctrl_data_rx_valid && !rx_ready)      err_d = 1'b1;

    case (state_q)
      IDLE: begin
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
        if (ctrl_addr_valid && !cs) begin
          base_d   = ctrl_addr;
          offset_d = 16'd0;
          state_d  = ctrl_rd_wr ? READ : WRITE;
        end
      end
      WRITE: begin
        if (bus_req_q) begin
          if (bus_gnt) bus_req_d = 1'b0;
        end else if (ctrl_data_rx_valid && !cs) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_wdata_d = ctrl_data_rx;
        end
        if (cs) state_d = DRAIN;
      end
      READ: begin
        bus_we_d = 1'b0;
        // a raised request must stay up until granted; otherwise refill against FIFO credit
        if (!(bus_req_q && !bus_gnt)) bus_req_d = !cs && (credit_used < PF_LIMIT);
        if (cs) state_d = DRAIN;
      end
      DRAIN: begin
        if (gnt_fire) bus_req_d = 1'b0;
        if (!bus_req_d && (outstanding_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!sys_rstn) begin
      state_q       <= IDLE;
      base_q        <= '0;
      offset_q      <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_wdata_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      offset_q      <= offset_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_wdata_q   <= bus_wdata_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // FIFO storage is data-only; validity lives entirely in count_q
  always_ff @(posedge sclk) begin
    if (sys_rstn && push_en && !flush) fifo_mem_q[wr_ptr_q] <= bus_rdata;
  end

  assign ctrl_data_rx_ready = rx_ready;
  assign ctrl_data_tx_valid = tx_valid;
  assign ctrl_data_tx       = tx_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign bus_req            = bus_req_q;
  assign bus_we             = bus_we_q;
  assign bus_wdata          = bus_wdata_q;
  assign bus_addr           = base_q + (ADDR_WIDTH'(offset_q) * ADDR_WIDTH'(BYTES));
  assign bus_be             = '1;
  assign busy               = (state_q != IDLE);
  assign err                = err_q;

endmodule

// File: tb/tb_spi_slave_bus_sequencer.sv
// Testbench for spi_slave_bus_sequencer: a bus responder with grant throttling and
// fixed read latency, plus scoreboard queues for writes, read addresses and TX data.
`timescale 1ns/1ps
module tb_spi_slave_bus_sequencer;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int PFD = 4;
  localparam int BIG = 1000000;

  logic          sclk = 1'b0;
  logic          sys_rstn = 1'b0;
  logic          cs = 1'b0;
  logic          ctrl_rd_wr = 1'b0;
  logic [AW-1:0] ctrl_addr = '0;
  logic          ctrl_addr_valid = 1'b0;
  logic [DW-1:0] ctrl_data_rx = '0;
  logic          ctrl_data_rx_valid = 1'b0;
  logic          ctrl_data_rx_ready;
  logic [DW-1:0] ctrl_data_tx;
  logic          ctrl_data_tx_valid;
  logic          ctrl_data_tx_ready = 1'b0;
  logic [15:0]   wrap_length = 16'd0;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW/8-1:0] bus_be;
  logic          bus_gnt = 1'b0;
  logic          bus_rvalid = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          busy;
  logic          err;

  spi_slave_bus_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PF_DEPTH(PFD)) dut (
    .sclk(sclk), .sys_rstn(sys_rstn), .cs(cs), .ctrl_rd_wr(ctrl_rd_wr),
    .ctrl_addr(ctrl_addr), .ctrl_addr_valid(ctrl_addr_valid),
    .ctrl_data_rx(ctrl_data_rx), .ctrl_data_rx_valid(ctrl_data_rx_valid),
    .ctrl_data_rx_ready(ctrl_data_rx_ready), .ctrl_data_tx(ctrl_data_tx),
    .ctrl_data_tx_valid(ctrl_data_tx_valid), .ctrl_data_tx_ready(ctrl_data_tx_ready),
    .wrap_length(wrap_length), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .busy(busy), .err(err)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int total_grants = 0;
  int gnt_limit = BIG;
  int rd_lat = 2;
  bit accept_rdata = 1'b1;
  bit spurious_rv = 1'b0;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [AW-1:0] addr; int due; } rd_t;
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] exp_tx[$];
  rd_t           pend[$];

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Bus responder: decides rvalid/gnt on the falling edge so the DUT samples them next rise
  task automatic responder();
    rd_t r;
    wr_t w;
    logic [AW-1:0] ea;
    forever begin
      @(negedge sclk);
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        r = pend.pop_front();
        bus_rvalid = 1'b1;
        bus_rdata  = memfn(r.addr);
        if (accept_rdata) exp_tx.push_back(memfn(r.addr));
      end else if (spurious_rv) begin
        bus_rvalid  = 1'b1;
        bus_rdata   = 32'hBAD0_BAD0;
        spurious_rv = 1'b0;
      end
      bus_gnt = 1'b0;
      if (bus_req === 1'b1 && sys_rstn && total_grants < gnt_limit) begin
        bus_gnt = 1'b1;
        total_grants++;
        if (bus_we) begin
          n_checks++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_write: got addr=%h data=%h, expected no write", bus_addr, bus_wdata);
          end else begin
            w = exp_wr.pop_front();
            if (bus_addr !== w.addr || bus_wdata !== w.data || bus_be !== 4'hF) begin
              n_fail++;
              $display("[TB] FAIL write_beat: got addr=%h data=%h be=%h, expected addr=%h data=%h be=f",
                       bus_addr, bus_wdata, bus_be, w.addr, w.data);
            end
          end
        end else begin
          n_checks++;
          if (exp_rd.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_read: got addr=%h, expected no read", bus_addr);
          end else begin
            ea = exp_rd.pop_front();
            if (bus_addr !== ea) begin
              n_fail++;
              $display("[TB] FAIL read_addr: got %h expected %h", bus_addr, ea);
            end
          end
          pend.push_back('{bus_addr, cyc + 1 + rd_lat});
        end
      end
    end
  endtask

  task automatic watchdog();
    #400000;
    n_checks++;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic start_session(input logic [AW-1:0] addr, input logic rw);
    step();
    ctrl_addr = addr;
    ctrl_rd_wr = rw;
    ctrl_addr_valid = 1'b1;
    step();
    ctrl_addr_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] data);
    bit done = 1'b0;
    int k = 0;
    while (!done && k < 20) begin
      if (ctrl_data_rx_ready) begin
        ctrl_data_rx_valid = 1'b1;
        ctrl_data_rx = data;
        step();
        ctrl_data_rx_valid = 1'b0;
        done = 1'b1;
      end else begin
        step();
        k++;
      end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("[TB] FAIL rx_ready_timeout: got ready=0, expected ready=1 within 20 cycles"); end
  endtask

  task automatic pop_tx(input string name);
    n_checks++;
    if (ctrl_data_tx_valid !== 1'b1 || exp_tx.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s_valid: got tx_valid=%b queued=%0d, expected tx_valid=1", name, ctrl_data_tx_valid, exp_tx.size());
    end else if (ctrl_data_tx !== exp_tx[0]) begin
      n_fail++;
      $display("[TB] FAIL %s_data: got %h expected %h", name, ctrl_data_tx, exp_tx[0]);
    end
    if (exp_tx.size() > 0) void'(exp_tx.pop_front());
    ctrl_data_tx_ready = 1'b1;
    step();
    ctrl_data_tx_ready = 1'b0;
  endtask

  task automatic end_session();
    int k = 0;
    while (pend.size() > 0 && k < 40) begin step(); k++; end
    accept_rdata = 1'b0;
    cs = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 30) begin step(); k++; end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL session_end: got busy=%b expected 0", busy); end
    cs = 1'b0;
    exp_tx.delete();
    accept_rdata = 1'b1;
    step();
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({bus_req, bus_we, ctrl_data_rx_ready, ctrl_data_tx_valid, busy, err} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got req=%b we=%b rxr=%b txv=%b busy=%b err=%b, expected all 0",
               bus_req, bus_we, ctrl_data_rx_ready, ctrl_data_tx_valid, busy, err);
    end
    n_checks++;
    if (bus_addr !== '0 || bus_wdata !== '0 || ctrl_data_tx !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h tx=%h, expected 0", bus_addr, bus_wdata, ctrl_data_tx);
    end
    n_checks++;
    if (bus_be !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_be: got %h expected f", bus_be); end
    sys_rstn = 1'b1;
    step();
  endtask

  task automatic test_write();
    wrap_length = 16'd0;
    exp_wr.push_back('{32'h1000, 32'hA});
    exp_wr.push_back('{32'h1004, 32'hB});
    exp_wr.push_back('{32'h1008, 32'hC});
    start_session(32'h1000, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    send_word(32'hA);
    send_word(32'hB);
    send_word(32'hC);
    repeat (3) step();
    n_checks++;
    if (exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL write_count: got %0d writes missing, expected 0", exp_wr.size()); end
    n_checks++;
    if (err !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_done: got err=%b req=%b, expected err=0 req=0", err, bus_req);
    end
    end_session();
  endtask

  task automatic test_read_prefetch();
    int g0;
    rd_lat = 2;
    ctrl_data_tx_ready = 1'b0;
    g0 = total_grants;
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h2000 + 32'(4 * i));
    start_session(32'h2000, 1'b1);
    repeat (15) step();
    n_checks++;
    if (total_grants - g0 != 4) begin n_fail++; $display("[TB] FAIL prefetch_reads: got %0d expected 4", total_grants - g0); end
    n_checks++;
    if (bus_req !== 1'b0) begin n_fail++; $display("[TB] FAIL prefetch_idle_req: got %b expected 0", bus_req); end
    n_checks++;
    if (ctrl_data_tx !== memfn(32'h2000)) begin
      n_fail++;
      $display("[TB] FAIL prefetch_head: got %h expected %h", ctrl_data_tx, memfn(32'h2000));
    end
    exp_rd.push_back(32'h2010);
    pop_tx("prefetch_pop");
    repeat (8) step();
    n_checks++;
    if (total_grants - g0 != 5 || exp_rd.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL prefetch_refill: got %0d reads, %0d missing, expected 5 reads, 0 missing", total_grants - g0, exp_rd.size());
    end
    n_checks++;
    if (ctrl_data_tx !== memfn(32'h2004)) begin
      n_fail++;
      $display("[TB] FAIL prefetch_next_head: got %h expected %h", ctrl_data_tx, memfn(32'h2004));
    end
    end_session();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] addrs [6];
    addrs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 32'h104};
    wrap_length = 16'd4;
    for (int i = 0; i < 6; i++) exp_wr.push_back('{addrs[i], 32'h100 + 32'(i)});
    start_session(32'h100, 1'b0);
    for (int i = 0; i < 6; i++) send_word(32'h100 + 32'(i));
    repeat (3) step();
    n_checks++;
    if (exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d writes missing, expected 0", exp_wr.size()); end
    end_session();
    wrap_length = 16'd0;
  endtask

  task automatic test_abort();
    int k = 0;
    rd_lat = 8;
    ctrl_data_tx_ready = 1'b0;
    gnt_limit = total_grants + 2;
    exp_rd.push_back(32'h3000);
    exp_rd.push_back(32'h3004);
    exp_rd.push_back(32'h3008);
    start_session(32'h3000, 1'b1);
    while (total_grants < gnt_limit && k < 20) begin step(); k++; end
    step();
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h3008) begin
      n_fail++;
      $display("[TB] FAIL abort_pending_req: got req=%b addr=%h, expected req=1 addr=00003008", bus_req, bus_addr);
    end
    accept_rdata = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus_req !== 1'b1 || ctrl_data_tx_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL abort_hold: got req=%b txv=%b busy=%b, expected req=1 txv=0 busy=1", bus_req, ctrl_data_tx_valid, busy);
      end
    end
    gnt_limit = total_grants + 1;
    k = 0;
    while ((pend.size() > 0 || bus_req === 1'b1 || total_grants < gnt_limit) && k < 60) begin
      n_checks++;
      if (busy !== 1'b1 || ctrl_data_tx_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL abort_drain: got busy=%b txv=%b, expected busy=1 txv=0", busy, ctrl_data_tx_valid);
      end
      step();
      k++;
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || ctrl_data_tx_valid !== 1'b0 || bus_req !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: got busy=%b txv=%b req=%b err=%b, expected all 0", busy, ctrl_data_tx_valid, bus_req, err);
    end
    n_checks++;
    if (exp_rd.size() != 0) begin n_fail++; $display("[TB] FAIL abort_reads: got %0d missing, expected 0", exp_rd.size()); end
    cs = 1'b0;
    exp_tx.delete();
    accept_rdata = 1'b1;
    rd_lat = 2;
    gnt_limit = BIG;
    step();
  endtask

  task automatic test_err_addr_valid();
    rd_lat = 2;
    ctrl_data_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h4000 + 32'(4 * i));
    start_session(32'h4000, 1'b1);
    repeat (10) step();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_before: got %b expected 0", err); end
    ctrl_addr = 32'h9000;
    ctrl_rd_wr = 1'b0;
    ctrl_addr_valid = 1'b1;
    step();
    ctrl_addr_valid = 1'b0;
    step();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_addr_valid: got err=%b busy=%b expected err=1 busy=1", err, busy);
    end
    exp_rd.push_back(32'h4010);
    pop_tx("err_pop");
    repeat (8) step();
    n_checks++;
    if (exp_rd.size() != 0) begin n_fail++; $display("[TB] FAIL err_base_kept: got %0d reads missing, expected 0", exp_rd.size()); end
    end_session();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid_write();
    gnt_limit = total_grants;
    start_session(32'h5000, 1'b0);
    send_word(32'h55);
    step();
    n_checks++;
    if (bus_req !== 1'b1 || bus_wdata !== 32'h55 || bus_addr !== 32'h5000) begin
      n_fail++;
      $display("[TB] FAIL rst_pending: got req=%b wdata=%h addr=%h expected req=1 wdata=00000055 addr=00005000", bus_req, bus_wdata, bus_addr);
    end
    sys_rstn = 1'b0;
    step();
    n_checks++;
    if ({bus_req, bus_we, ctrl_data_rx_ready, ctrl_data_tx_valid, busy, err} !== 6'b0 ||
        bus_addr !== '0 || bus_wdata !== '0 || ctrl_data_tx !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_write: got req=%b we=%b rxr=%b busy=%b err=%b addr=%h wdata=%h, expected all 0",
               bus_req, bus_we, ctrl_data_rx_ready, busy, err, bus_addr, bus_wdata);
    end
    sys_rstn = 1'b1;
    gnt_limit = BIG;
    repeat (3) step();
    n_checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_after: got req=%b busy=%b expected 0 0", bus_req, busy);
    end
  endtask

  task automatic test_err_spurious_rvalid();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_before: got %b expected 0", err); end
    spurious_rv = 1'b1;
    step();
    step();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_rvalid: got %b expected 1", err); end
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL spur_sticky: got err=%b busy=%b expected err=1 busy=0", err, busy);
    end
  endtask

  initial begin
    fork
      responder();
      watchdog();
    join_none
    $display("[TB] starting spi_slave_bus_sequencer bench");
    test_reset();
    test_write();
    test_read_prefetch();
    test_wrap();
    test_abort();
    test_err_addr_valid();
    test_reset_mid_write();
    test_err_spurious_rvalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
